// File: rtl/sdram_burst_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_burst_scheduler
//
// Purpose:
//    Arbitrates SDRAM write and read bursts for a ring buffer that lives in
//    SDRAM. A write burst moves BURST_LEN words from the input FIFO into the
//    ring at wr_ptr. A read burst moves BURST_LEN words from the ring at rd_ptr
//    into the output FIFO. When both kinds are eligible, grants alternate
//    round-robin. Each command is a req/ack/done handshake with the controller.
//    Protocol violations from the controller raise a sticky fault flag.
//
// Ports:
//    sdram_clk       in   sole clock, rising edge
//    sdram_rst       in   synchronous active-high reset
//    sdram_wren      in   enables write bursts (sampled only in IDLE)
//    sdram_rden      in   enables read bursts (sampled only in IDLE)
//    wr_fifo_count   in   words waiting in the input FIFO
//    rd_fifo_count   in   words held in the output FIFO
//    sdram_cmd_ack   in   controller accepted the command
//    sdram_cmd_done  in   controller finished the burst
//    sdram_cmd_wr    out  write-burst request (registered)
//    sdram_cmd_rd    out  read-burst request (registered)
//    sdram_addr      out  burst address (registered)
//    sdram_full      out  ring holds 2^ADDR_WIDTH bursts
//    sdram_empty     out  ring holds no bursts
//    sdram_count     out  bursts stored in the ring
//    state           out  current FSM state
//    fault_spurious  out  sticky protocol-fault flag
// -----------------------------------------------------------------------------
module sdram_burst_scheduler #(
   parameter int ADDR_WIDTH = 15,
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 512,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                  sdram_clk,
   input  logic                  sdram_rst,
   input  logic                  sdram_wren,
   input  logic                  sdram_rden,
   input  logic [CNT_WIDTH-1:0]  wr_fifo_count,
   input  logic [CNT_WIDTH-1:0]  rd_fifo_count,
   input  logic                  sdram_cmd_ack,
   input  logic                  sdram_cmd_done,
   output logic                  sdram_cmd_wr,
   output logic                  sdram_cmd_rd,
   output logic [ADDR_WIDTH-1:0] sdram_addr,
   output logic                  sdram_full,
   output logic                  sdram_empty,
   output logic [ADDR_WIDTH:0]   sdram_count,
   output logic [2:0]            state,
   output logic                  fault_spurious
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_WAIT = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_WAIT = 3'd4
   } state_t;

   localparam logic GRANT_WR = 1'b0;
   localparam logic GRANT_RD = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO   = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(32'd1);
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(32'd1);
   localparam logic [ADDR_WIDTH:0]   RING_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   localparam logic [31:0] BURST_W = 32'(BURST_LEN);
   localparam logic [31:0] DEPTH_W = 32'(FIFO_DEPTH);

   state_t                  state_r;
   logic                    cmd_wr_r;
   logic                    cmd_rd_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ADDR_WIDTH-1:0]   wr_ptr_r;
   logic [ADDR_WIDTH-1:0]   rd_ptr_r;
   logic [ADDR_WIDTH:0]     count_r;
   logic                    fault_r;
   logic                    last_grant_r;

   logic [31:0]             wr_cnt_ext_s;
   logic [31:0]             rd_cnt_ext_s;
   logic                    wr_elig_s;
   logic                    rd_elig_s;
   logic                    spurious_s;

   assign sdram_full  = (count_r == RING_DEPTH);
   assign sdram_empty = (count_r == CNT_ZERO);

   assign wr_cnt_ext_s = 32'(wr_fifo_count);
   assign rd_cnt_ext_s = 32'(rd_fifo_count);

   // Burst eligibility and spurious handshake detection.
   always_comb begin
      wr_elig_s = sdram_wren && (wr_cnt_ext_s >= BURST_W) && !sdram_full;
      // A count above FIFO_DEPTH means no free space, never wrapped-around space.
      rd_elig_s = sdram_rden && (rd_cnt_ext_s <= DEPTH_W) &&
                  ((DEPTH_W - rd_cnt_ext_s) >= BURST_W) && !sdram_empty;
      if (state_r == ST_IDLE) begin
         spurious_s = sdram_cmd_done || sdram_cmd_ack;
      end else if ((state_r == ST_WR_WAIT) || (state_r == ST_RD_WAIT)) begin
         spurious_s = sdram_cmd_ack;
      end else begin
         spurious_s = 1'b0;
      end
   end

   // Scheduler FSM with its registered command, address and ring bookkeeping.
   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         state_r      <= ST_IDLE;
         cmd_wr_r     <= 1'b0;
         cmd_rd_r     <= 1'b0;
         addr_r       <= PTR_ZERO;
         wr_ptr_r     <= PTR_ZERO;
         rd_ptr_r     <= PTR_ZERO;
         count_r      <= CNT_ZERO;
         fault_r      <= 1'b0;
         last_grant_r <= GRANT_RD;
      end else begin
         if (spurious_s) begin
            fault_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               // On contention, grant the type that did not win last time.
               if (wr_elig_s && (!rd_elig_s || (last_grant_r == GRANT_RD))) begin
                  state_r      <= ST_WR_REQ;
                  cmd_wr_r     <= 1'b1;
                  addr_r       <= wr_ptr_r;
                  last_grant_r <= GRANT_WR;
               end else if (rd_elig_s) begin
                  state_r      <= ST_RD_REQ;
                  cmd_rd_r     <= 1'b1;
                  addr_r       <= rd_ptr_r;
                  last_grant_r <= GRANT_RD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WR_REQ: begin
               // Ack together with done completes the burst in one step.
               if (sdram_cmd_ack && sdram_cmd_done) begin
                  state_r  <= ST_IDLE;
                  cmd_wr_r <= 1'b0;
                  wr_ptr_r <= wr_ptr_r + PTR_ONE;
                  if (!sdram_full) begin
                     count_r <= count_r + CNT_ONE;
                  end
               end else if (sdram_cmd_ack) begin
                  state_r  <= ST_WR_WAIT;
                  cmd_wr_r <= 1'b0;
               end else begin
                  state_r <= ST_WR_REQ;
               end
            end
            ST_WR_WAIT: begin
               if (sdram_cmd_done) begin
                  state_r  <= ST_IDLE;
                  wr_ptr_r <= wr_ptr_r + PTR_ONE;
                  if (!sdram_full) begin
                     count_r <= count_r + CNT_ONE;
                  end
               end else begin
                  state_r <= ST_WR_WAIT;
               end
            end
            ST_RD_REQ: begin
               if (sdram_cmd_ack && sdram_cmd_done) begin
                  state_r  <= ST_IDLE;
                  cmd_rd_r <= 1'b0;
                  rd_ptr_r <= rd_ptr_r + PTR_ONE;
                  if (!sdram_empty) begin
                     count_r <= count_r - CNT_ONE;
                  end
               end else if (sdram_cmd_ack) begin
                  state_r  <= ST_RD_WAIT;
                  cmd_rd_r <= 1'b0;
               end else begin
                  state_r <= ST_RD_REQ;
               end
            end
            ST_RD_WAIT: begin
               if (sdram_cmd_done) begin
                  state_r  <= ST_IDLE;
                  rd_ptr_r <= rd_ptr_r + PTR_ONE;
                  if (!sdram_empty) begin
                     count_r <= count_r - CNT_ONE;
                  end
               end else begin
                  state_r <= ST_RD_WAIT;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               cmd_wr_r <= 1'b0;
               cmd_rd_r <= 1'b0;
            end
         endcase
      end
   end

   assign sdram_cmd_wr   = cmd_wr_r;
   assign sdram_cmd_rd   = cmd_rd_r;
   assign sdram_addr     = addr_r;
   assign sdram_count    = count_r;
   assign state          = state_r;
   assign fault_spurious = fault_r;

endmodule

// File: doc/sdram_burst_scheduler.md
SDRAM_BURST_SCHEDULER -- requirements
Module: sdram_burst_scheduler

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 15, giving the SDRAM burst-address width; the ring depth is 2^ADDR_WIDTH bursts.
REQ-002 The block SHALL have parameter BURST_LEN, default 8, giving the words per SDRAM command.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 512, giving the output-FIFO capacity in words.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 10, giving the width of the FIFO count inputs.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset:
- sdram_clk  in  1  sole clock; all state changes on its rising edge.
- sdram_rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have these enables and FIFO status inputs:
- sdram_wren  in  1  enables SDRAM write bursts.
- sdram_rden  in  1  enables SDRAM read bursts.
- wr_fifo_count  in  CNT_WIDTH  words waiting in the input FIFO.
- rd_fifo_count  in  CNT_WIDTH  words held in the output FIFO.
REQ-007 The block SHALL have this SDRAM command port:
- sdram_cmd_ack  in  1  controller accepted the command.
- sdram_cmd_done  in  1  controller finished the burst.
- sdram_cmd_wr  out  1  write-burst request.
- sdram_cmd_rd  out  1  read-burst request.
- sdram_addr  out  ADDR_WIDTH  burst address.
REQ-008 The block SHALL have these status outputs:
- sdram_full  out  1  ring full.
- sdram_empty  out  1  ring empty.
- sdram_count  out  ADDR_WIDTH+1  bursts stored.
- state  out  3  current FSM state.
- fault_spurious  out  1  sticky protocol-fault flag.

Function
REQ-009 The FSM SHALL have states IDLE=0, WR_REQ=1, WR_WAIT=2, RD_REQ=3 and RD_WAIT=4; all other encodings SHALL go to IDLE.
REQ-010 A write is eligible when sdram_wren=1, wr_fifo_count>=BURST_LEN and sdram_full=0.
REQ-011 A read is eligible when sdram_rden=1, (FIFO_DEPTH-rd_fifo_count)>=BURST_LEN and sdram_empty=0.
REQ-012 In IDLE, the FSM SHALL go to WR_REQ if only a write is eligible and to RD_REQ if only a read is eligible.
REQ-013 In IDLE with both eligible, the FSM SHALL grant the type opposite to last_grant (round-robin).
REQ-014 last_grant SHALL update at each grant.
REQ-015 The command outputs SHALL be registered: sdram_cmd_wr=1 exactly while state=WR_REQ, and sdram_cmd_rd=1 exactly while state=RD_REQ.
REQ-016 The first command SHALL appear one cycle after the eligible cycle in IDLE.
REQ-017 While the FSM is in WR_REQ or WR_WAIT, sdram_addr SHALL equal wr_ptr.
REQ-018 While the FSM is in RD_REQ or RD_WAIT, sdram_addr SHALL equal rd_ptr.
REQ-019 While the FSM is in IDLE, sdram_addr SHALL hold its last value.
REQ-020 In xx_REQ, the command SHALL stay asserted until sdram_cmd_ack=1; the FSM then SHALL go to xx_WAIT, and the command SHALL be low on the next cycle.
REQ-021 In xx_WAIT, on sdram_cmd_done=1 the FSM SHALL go to IDLE.
REQ-022 On a write done, wr_ptr SHALL increment by 1 and sdram_count SHALL increment by 1, on the same edge as the IDLE transition.
REQ-023 On a read done, rd_ptr SHALL increment by 1 and sdram_count SHALL decrement by 1, on the same edge as the IDLE transition.
REQ-024 If ack and done are asserted in the same cycle in xx_REQ, the block SHALL treat it as completion: go directly to IDLE and apply the pointer and count update.
REQ-025 The minimum command-to-command spacing SHALL be: done cycle, then one IDLE cycle, then the new command.
REQ-026 Pointers SHALL wrap from 2^ADDR_WIDTH-1 to 0 modulo 2^ADDR_WIDTH.
REQ-027 sdram_count SHALL never exceed 2^ADDR_WIDTH and SHALL never underflow.
REQ-028 sdram_full SHALL be 1 iff sdram_count==2^ADDR_WIDTH, and sdram_empty SHALL be 1 iff sdram_count==0; both SHALL be combinational from the count register.
REQ-029 fault_spurious SHALL set on sdram_cmd_done=1 in IDLE, or on sdram_cmd_ack=1 in IDLE or xx_WAIT.
REQ-030 fault_spurious SHALL clear only on reset; the spurious event SHALL be otherwise ignored, with no state change.
REQ-031 Deasserting sdram_wren or sdram_rden while a command is in progress SHALL NOT abort it; the enables are sampled only in IDLE.

Reset
REQ-032 On sdram_rst=1 at a rising edge, the block SHALL set: state=IDLE, sdram_cmd_wr=0, sdram_cmd_rd=0, sdram_addr=0, wr_ptr=0, rd_ptr=0, sdram_count=0, fault_spurious=0, last_grant=read.
REQ-033 As a result of REQ-032, sdram_empty=1, sdram_full=0, and the first contested grant SHALL be a write.
REQ-034 A reset mid-operation SHALL drop the command on the next edge with no pointer update.
REQ-035 A done that arrives after a reset SHALL set fault_spurious.

Verification
REQ-036 Single write: wren=1, wr_fifo_count=8 -> cmd_wr high the next cycle, addr=0.
- Ack after 3 cycles -> cmd_wr low the next cycle.
- Done -> count=1, empty=0, wr_ptr=1.
REQ-037 Round-robin: ring count=2, wr_fifo_count=16, rd_fifo_count=0, both enabled, immediate ack+done -> grants alternate W,R,W,R starting with W; sdram_addr sequence 2,0,3,1.
REQ-038 Full/wrap: ADDR_WIDTH=3, continuous writes -> 8 bursts at addr 0..7, then full=1 and no cmd_wr.
- One read -> full=0; the next write uses addr 0.
REQ-039 Output space: rd_fifo_count=505 with FIFO_DEPTH=512 -> no cmd_rd; rd_fifo_count=504 -> cmd_rd issued.
REQ-040 Faults: done pulse in IDLE -> fault_spurious=1 and it stays set; reset -> 0.
- Same-cycle ack+done in WR_REQ -> IDLE next cycle, count+1, no fault.
REQ-041 Reset in WR_WAIT -> next cycle state=IDLE, count=0, cmd_wr=0; a later done -> fault_spurious=1.
